ft601_mcfifo_pkt_buf: RTL and testbench
=======================================

// Module: ft601_mcfifo_pkt_buf
// PURPOSE
//  Single-clock, multi-channel packetising write buffer in front of the FT601 multi-channel FIFO master.
//  Generalises the single-channel write buffer to NUM_CH channels sharing one word RAM.
//  Each channel accumulates words into packets of max_packet_size bytes; wr_push flushes a partial packet.
//  A round-robin arbiter presents one committed packet at a time to the USB-side transfer engine.
// PARAMETERS
//  NUM_CH           4     channel count, 1/2/4
//  DATA_W           36    word width, 32 data + 4 byte-enable
//  DEPTH            1024  words per channel, power of 2, >= MAX_PACKET_SIZE/4
//  MAX_PACKET_SIZE  4096  largest legal max_packet_size, bytes
//  ALMOST_MARGIN    8     free-word threshold for almost_unwriteable
//  AUTOPUSH_CYCLES  1024  idle cycles before auto-flush (MCFIFO_PKT_BUF_AUTOPUSH_EN only)
// PORTS
//  clk                  in   1          single clock
//  reset                in   1          asynchronous, active-high
//  max_packet_size      in   32         packet size, bytes; multiple of 4; static while rd_xfer_req=1
//  wr_ch                in   CW         target channel; CW=max(1,$clog2(NUM_CH))
//  wr_data              in   DATA_W     write word
//  wr_en                in   1          write wr_data to wr_ch
//  wr_push              in   1          commit partial packet of wr_ch
//  writeable            out  NUM_CH     per channel: free >= 1
//  almost_unwriteable   out  NUM_CH     per channel: free <= ALMOST_MARGIN
//  overflow             out  NUM_CH     sticky: write dropped on full channel
//  rd_ch                out  CW         channel of current transfer
//  rd_xfer_req          out  1          packet available, transfer in progress
//  rd_en                in   1          consume one word; ignored unless rd_xfer_req=1 and words remain
//  rd_data              out  DATA_W     read word
//  rd_valid             out  1          rd_data valid
//  rd_xfer_almost_done  out  1          exactly one word left in transfer
//  rd_xfer_done         out  1          1-cycle pulse, transfer complete
// BEHAVIOUR
//  - Reset: all outputs 0 except writeable all 1. All pointers, counts and commits cleared. Overflow is cleared.
//    Reset mid-transfer discards all data; no done pulse.
//  - Storage: one RAM of NUM_CH*DEPTH words at addr {ch,ptr}. Per-channel wptr, rptr, count, committed, uncommitted.
//  - pkt_words = max_packet_size>>2, clamped to [1, MAX_PACKET_SIZE/4]. Sampled each cycle on the write side.
//  - Write: wr_en with count<DEPTH stores the word; uncommitted++.
//    If uncommitted reaches pkt_words, it is moved to committed the same cycle.
//    wr_en when full drops the word and sets overflow[wr_ch].
//  - Push: wr_push moves uncommitted to committed. wr_en+wr_push in the same cycle includes that word.
//    Push with uncommitted=0 is a no-op.
//  - Committed is tracked as a FIFO of packet lengths per channel, max DEPTH entries, so pushed short packets keep their boundaries.
//  - FSM IDLE: scan from last_ch+1 round-robin for a channel with a committed packet.
//    On a hit, latch ch and len, go to XFER. The next cycle rd_xfer_req=1 and rd_ch=ch.
//  - FSM XFER: each rd_en reads one word; rd_valid/rd_data follow 1 cycle later (registered RAM).
//    rd_xfer_almost_done=1 while remaining==1. After the last rd_en, go to DONE.
//  - FSM DONE: rd_xfer_done=1 and rd_xfer_req=0 for 1 cycle; last_ch=ch; go to IDLE.
//    Consumers may drive rd_en = rd_xfer_req && !rd_xfer_done.
//  - rd_en with remaining=0 or in IDLE/DONE is ignored: no pointer move, rd_valid=0.
//  - Simultaneous write and read on the same channel is legal. count updates with net +1/0/-1; free space is freed on read.
//  - writeable/almost_unwriteable are registered from next-cycle count, so they carry no combinational path to wr_*.
//  - Pointer wrap: modulo DEPTH, natural binary rollover.
// CONFIGURATION
//  MCFIFO_PKT_BUF_AUTOPUSH_EN defined:
//    per-channel idle timer, reset by wr_en/wr_push to that channel.
//    At AUTOPUSH_CYCLES with uncommitted>0, it performs an internal push.
//  Undefined: no timers; partial packets are committed only by wr_push or filling.
// TESTING
//  1) NUM_CH=1, max_packet_size=64, write 16 words 1..16
//     -> one transfer: 16 rd_valid words 1..16, almost_done on word 16, done pulse once.
//  2) Write 32 words -> two 16-word transfers back to back, data 1..32, two done pulses.
//  3) Write 8 words then wr_push -> one 8-word transfer; without push, rd_xfer_req stays 0.
//  4) NUM_CH=4, 16 words to each channel in one burst
//     -> rd_ch order 0,1,2,3; each payload intact, with channel id in the data MSBs.
//  5) Fill ch2 with DEPTH+3 words, no reads -> writeable[2]=0, overflow[2]=1, 3 words lost.
//     Other channels are unaffected; reset clears overflow.
//  6) AUTOPUSH_EN, AUTOPUSH_CYCLES=100: write 5 words to ch1, then idle
//     -> rd_xfer_req about 101 cycles later, 5-word transfer.
//     Reset asserted mid-transfer -> req/valid 0 asynchronously, FIFO empty.

Source files
------------

// File: rtl/ft601_mcfifo_pkt_buf.sv
// ft601_mcfifo_pkt_buf
//   Single-clock, multi-channel packetising write buffer in front of the FT601 multi-channel
//   FIFO master. NUM_CH channels share one word RAM addressed {ch, ptr}. Each channel gathers
//   words into packets of max_packet_size bytes; wr_push flushes a partial packet. Committed
//   packet lengths are queued per channel so short pushed packets keep their boundaries. A
//   round-robin arbiter hands one committed packet at a time to the USB-side transfer engine.
//
//   Optional feature: define MCFIFO_PKT_BUF_AUTOPUSH_EN to give each channel an idle timer
//   that pushes a partial packet after AUTOPUSH_CYCLES cycles without wr_en/wr_push.
//
// Ports
//   clk, reset           single clock, asynchronous active-high reset
//   max_packet_size      packet size in bytes (multiple of 4)
//   wr_ch/wr_data        target channel and word for wr_en / wr_push
//   wr_en, wr_push       store a word / commit the partial packet of wr_ch
//   writeable            per channel: at least one free word
//   almost_unwriteable   per channel: free words <= ALMOST_MARGIN
//   overflow             per channel, sticky: a write was dropped because the channel was full
//   rd_ch, rd_xfer_req   channel of the packet being transferred, transfer in progress
//   rd_en                consume one word of the current transfer
//   rd_data, rd_valid    read word, valid one cycle after the accepted rd_en
//   rd_xfer_almost_done  exactly one word left in the transfer
//   rd_xfer_done         one-cycle pulse when the transfer has completed
module ft601_mcfifo_pkt_buf #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned DATA_W          = 36,
    parameter int unsigned DEPTH           = 1024,
    parameter int unsigned MAX_PACKET_SIZE = 4096,
    parameter int unsigned ALMOST_MARGIN   = 8,
    parameter int unsigned AUTOPUSH_CYCLES = 1024,
    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       max_packet_size,
    input  logic [CW-1:0]     wr_ch,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic              wr_push,
    output logic [NUM_CH-1:0] writeable,
    output logic [NUM_CH-1:0] almost_unwriteable,
    output logic [NUM_CH-1:0] overflow,
    output logic [CW-1:0]     rd_ch,
    output logic              rd_xfer_req,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_xfer_almost_done,
    output logic              rd_xfer_done
);
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CNW  = PW + 1;
    localparam int unsigned AW   = $clog2(NUM_CH * DEPTH);
    localparam int unsigned MAXW = MAX_PACKET_SIZE / 4;
    localparam int unsigned LW   = $clog2(MAXW) + 1;

    typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

    // With a single channel the channel bit is always zero and is dropped here.
    function automatic logic [AW-1:0] ram_addr(input logic [CW-1:0] ch, input logic [PW-1:0] ptr);
        return AW'({ch, ptr});
    endfunction

    logic [DATA_W-1:0] mem     [NUM_CH*DEPTH];
    logic [LW-1:0]     len_mem [NUM_CH*DEPTH];

    logic [PW-1:0]  wptr      [NUM_CH];
    logic [PW-1:0]  rptr      [NUM_CH];
    logic [PW-1:0]  lwptr     [NUM_CH];
    logic [PW-1:0]  lrptr     [NUM_CH];
    logic [CNW-1:0] count     [NUM_CH];
    logic [CNW-1:0] count_nxt [NUM_CH];
    logic [CNW-1:0] pkt_cnt   [NUM_CH];
    logic [LW-1:0]  unc       [NUM_CH];

    state_e        state;
    logic [CW-1:0] last_ch;
    logic [LW-1:0] remaining;

    // Packet size in words, clamped to [1, MAXW].
    logic [29:0]   mps_words;
    logic [LW-1:0] pkt_words;
    logic          unused_mps_lsb;

    assign mps_words      = max_packet_size[31:2];
    assign unused_mps_lsb = ^max_packet_size[1:0];

    always_comb begin
        if (mps_words == '0) begin
            pkt_words = LW'(1);
        end else if (mps_words > 30'(MAXW)) begin
            pkt_words = LW'(MAXW);
        end else begin
            pkt_words = LW'(mps_words);
        end
    end

    // Write side
    logic          wr_ok, wr_commit;
    logic [LW-1:0] wr_unc_nxt;
    logic          cm_valid;
    logic [CW-1:0] cm_ch;
    logic [LW-1:0] cm_len;

    assign wr_ok      = wr_en && (count[wr_ch] != CNW'(DEPTH));
    assign wr_unc_nxt = unc[wr_ch] + LW'(wr_ok);
    assign wr_commit  = (wr_ok && (wr_unc_nxt >= pkt_words)) || (wr_push && (wr_unc_nxt != '0));

`ifdef MCFIFO_PKT_BUF_AUTOPUSH_EN
    localparam int unsigned TW = $clog2(AUTOPUSH_CYCLES + 1);

    logic [TW-1:0] ap_timer [NUM_CH];

    // One length-queue write per cycle: an expired timer simply waits while the write side
    // is committing, and the lowest expired channel goes first.
    always_comb begin
        cm_valid = wr_commit;
        cm_ch    = wr_ch;
        cm_len   = wr_unc_nxt;
        if (!wr_commit) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!cm_valid && (ap_timer[c] >= TW'(AUTOPUSH_CYCLES)) && (unc[c] != '0) &&
                    !((wr_en || wr_push) && (wr_ch == CW'(c)))) begin
                    cm_valid = 1'b1;
                    cm_ch    = CW'(c);
                    cm_len   = unc[c];
                end
            end
        end
    end
`else
    logic [31:0] unused_autopush;
    assign unused_autopush = AUTOPUSH_CYCLES;

    always_comb begin
        cm_valid = wr_commit;
        cm_ch    = wr_ch;
        cm_len   = wr_unc_nxt;
    end
`endif

    // Read side and round-robin scan starting after the last served channel
    logic          rd_fire, hit, pop;
    logic [CW-1:0] hit_ch, scan_ch;
    logic [LW-1:0] hit_len;

    assign rd_fire = (state == StXfer) && rd_en && (remaining != '0);

    always_comb begin
        hit     = 1'b0;
        hit_ch  = '0;
        scan_ch = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            scan_ch = CW'((32'(last_ch) + 32'(i) + 32'd1) % NUM_CH);
            if (!hit && (pkt_cnt[scan_ch] != '0)) begin
                hit    = 1'b1;
                hit_ch = scan_ch;
            end
        end
    end

    assign hit_len = len_mem[ram_addr(hit_ch, lrptr[hit_ch])];
    assign pop     = (state == StIdle) && hit;

    // Per-channel strobes
    logic [NUM_CH-1:0] wr_v, rd_v, cm_v, pop_v, ovf_v;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            wr_v[c]      = wr_ok && (wr_ch == CW'(c));
            ovf_v[c]     = wr_en && !wr_ok && (wr_ch == CW'(c));
            rd_v[c]      = rd_fire && (rd_ch == CW'(c));
            cm_v[c]      = cm_valid && (cm_ch == CW'(c));
            pop_v[c]     = pop && (hit_ch == CW'(c));
            count_nxt[c] = count[c] + CNW'(wr_v[c]) - CNW'(rd_v[c]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wptr[c]    <= '0;
                rptr[c]    <= '0;
                lwptr[c]   <= '0;
                lrptr[c]   <= '0;
                count[c]   <= '0;
                pkt_cnt[c] <= '0;
                unc[c]     <= '0;
            end
            overflow           <= '0;
            writeable          <= '1;
            almost_unwriteable <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_v[c]) wptr[c] <= wptr[c] + 1'b1;
                if (rd_v[c]) rptr[c] <= rptr[c] + 1'b1;
                if (cm_v[c]) lwptr[c] <= lwptr[c] + 1'b1;
                if (pop_v[c]) lrptr[c] <= lrptr[c] + 1'b1;
                if (cm_v[c]) begin
                    unc[c] <= '0;
                end else if (wr_v[c]) begin
                    unc[c] <= unc[c] + 1'b1;
                end
                count[c]   <= count_nxt[c];
                pkt_cnt[c] <= pkt_cnt[c] + CNW'(cm_v[c]) - CNW'(pop_v[c]);
                if (ovf_v[c]) overflow[c] <= 1'b1;
                writeable[c]          <= (count_nxt[c] != CNW'(DEPTH));
                almost_unwriteable[c] <= ((CNW'(DEPTH) - count_nxt[c]) <= CNW'(ALMOST_MARGIN));
            end
        end
    end

`ifdef MCFIFO_PKT_BUF_AUTOPUSH_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) ap_timer[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (((wr_en || wr_push) && (wr_ch == CW'(c))) || cm_v[c]) begin
                    ap_timer[c] <= '0;
                end else if (ap_timer[c] < TW'(AUTOPUSH_CYCLES)) begin
                    ap_timer[c] <= ap_timer[c] + 1'b1;
                end
            end
        end
    end
`endif

    // Storage: data RAM and packet-length RAM, one write port each
    always_ff @(posedge clk) begin
        if (wr_ok) mem[ram_addr(wr_ch, wptr[wr_ch])] <= wr_data;
        if (cm_valid) len_mem[ram_addr(cm_ch, lwptr[cm_ch])] <= cm_len;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) rd_data <= mem[ram_addr(rd_ch, rptr[rd_ch])];
        end
    end

    // Transfer FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= StIdle;
            rd_ch               <= '0;
            last_ch             <= CW'(NUM_CH - 1);
            remaining           <= '0;
            rd_xfer_req         <= 1'b0;
            rd_xfer_almost_done <= 1'b0;
            rd_xfer_done        <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (hit) begin
                        state               <= StXfer;
                        rd_ch               <= hit_ch;
                        remaining           <= hit_len;
                        rd_xfer_req         <= 1'b1;
                        rd_xfer_almost_done <= (hit_len == LW'(1));
                    end
                end
                StXfer: begin
                    if (rd_fire) begin
                        remaining           <= remaining - 1'b1;
                        rd_xfer_almost_done <= (remaining == LW'(2));
                        if (remaining == LW'(1)) begin
                            state        <= StDone;
                            rd_xfer_req  <= 1'b0;
                            rd_xfer_done <= 1'b1;
                            last_ch      <= rd_ch;
                        end
                    end
                end
                StDone: begin
                    rd_xfer_done <= 1'b0;
                    state        <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ft601_mcfifo_pkt_buf.sv
// Directed bench for ft601_mcfifo_pkt_buf: packetising, push, round robin, overflow,
// asynchronous reset and (when the macro is defined) idle auto-push.
module tb_ft601_mcfifo_pkt_buf;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DATA_W = 36;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned CW     = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       max_packet_size;
    logic [CW-1:0]     wr_ch;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              wr_push;
    logic [NUM_CH-1:0] writeable;
    logic [NUM_CH-1:0] almost_unwriteable;
    logic [NUM_CH-1:0] overflow;
    logic [CW-1:0]     rd_ch;
    logic              rd_xfer_req;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_xfer_almost_done;
    logic              rd_xfer_done;

    ft601_mcfifo_pkt_buf #(
        .NUM_CH          (NUM_CH),
        .DATA_W          (DATA_W),
        .DEPTH           (DEPTH),
        .MAX_PACKET_SIZE (4096),
        .ALMOST_MARGIN   (8),
        .AUTOPUSH_CYCLES (100)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .max_packet_size     (max_packet_size),
        .wr_ch               (wr_ch),
        .wr_data             (wr_data),
        .wr_en               (wr_en),
        .wr_push             (wr_push),
        .writeable           (writeable),
        .almost_unwriteable  (almost_unwriteable),
        .overflow            (overflow),
        .rd_ch               (rd_ch),
        .rd_xfer_req         (rd_xfer_req),
        .rd_en               (rd_en),
        .rd_data             (rd_data),
        .rd_valid            (rd_valid),
        .rd_xfer_almost_done (rd_xfer_almost_done),
        .rd_xfer_done        (rd_xfer_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] got_q [$];
    int                almost_q [$];
    logic [CW-1:0]     ch_q [$];
    int                done_cnt;
    logic              req_prev;
    logic              consume;

    int n1, n2, bad1, bad2, base_got, base_done, base_ch, lat;
    logic [DATA_W-1:0] last2;

    function automatic logic [DATA_W-1:0] mk(input int ch, input int i);
        return {4'(ch), 32'(i)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled on the falling edge, where the next rd_en is also chosen.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (rd_valid) got_q.push_back(rd_data);
        if (rd_xfer_almost_done) almost_q.push_back(got_q.size());
        if (rd_xfer_done) done_cnt++;
        if (rd_xfer_req && !req_prev) ch_q.push_back(rd_ch);
        req_prev = rd_xfer_req;
        rd_en = consume && rd_xfer_req && !rd_xfer_done;
    endtask

    task automatic wr(input int ch, input logic [DATA_W-1:0] d, input logic push);
        wr_ch   = CW'(ch);
        wr_data = d;
        wr_en   = 1'b1;
        wr_push = push;
        tick();
        wr_en   = 1'b0;
        wr_push = 1'b0;
    endtask

    task automatic push_only(input int ch);
        wr_ch   = CW'(ch);
        wr_push = 1'b1;
        tick();
        wr_push = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(done_cnt), 64'(target));
    endtask

    task automatic clear_mon();
        got_q.delete();
        almost_q.delete();
        ch_q.delete();
        done_cnt = 0;
    endtask

    initial begin
        reset           = 1'b1;
        max_packet_size = 32'd64;
        wr_ch           = '0;
        wr_data         = '0;
        wr_en           = 1'b0;
        wr_push         = 1'b0;
        rd_en           = 1'b0;
        consume         = 1'b1;
        req_prev        = 1'b0;
        done_cnt        = 0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_writeable", 64'(writeable), 64'(4'hf));
        check("rst_almost", 64'(almost_unwriteable), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_req", 64'(rd_xfer_req), 64'(0));
        check("rst_valid_data", 64'({rd_valid, rd_data}), 64'(0));
        check("rst_done_almost_ch", 64'({rd_xfer_done, rd_xfer_almost_done, rd_ch}), 64'(0));
        reset = 1'b0;

        // 1) one full 16-word packet on ch0
        clear_mon();
        for (int i = 1; i <= 16; i++) wr(0, mk(0, i), 1'b0);
        wait_done("t1_done", 1, 100);
        repeat (5) tick();
        check("t1_done_once", 64'(done_cnt), 64'(1));
        check("t1_words", 64'(got_q.size()), 64'(16));
        for (int i = 0; i < got_q.size(); i++) check("t1_data", 64'(got_q[i]), 64'(mk(0, i + 1)));
        check("t1_almost_cnt", 64'(almost_q.size()), 64'(1));
        check("t1_almost_pos", 64'(almost_q[0]), 64'(15));
        check("t1_ch", 64'(ch_q[0]), 64'(0));

        // 2) 32 words -> two back-to-back 16-word transfers
        clear_mon();
        for (int i = 1; i <= 32; i++) wr(0, mk(0, i), 1'b0);
        wait_done("t2_done", 2, 200);
        check("t2_words", 64'(got_q.size()), 64'(32));
        for (int i = 0; i < got_q.size(); i++) check("t2_data", 64'(got_q[i]), 64'(mk(0, i + 1)));
        check("t2_xfers", 64'(ch_q.size()), 64'(2));
        check("t2_almost_a", 64'(almost_q[0]), 64'(15));
        check("t2_almost_b", 64'(almost_q[1]), 64'(31));

        // 3) partial packet waits for wr_push; push with data on the same cycle; empty push
        clear_mon();
        for (int i = 1; i <= 8; i++) wr(0, mk(0, i), 1'b0);
        repeat (30) tick();
        check("t3_no_req_xfers", 64'(ch_q.size()), 64'(0));
        check("t3_no_req", 64'(rd_xfer_req), 64'(0));
        push_only(0);
        wait_done("t3_push_done", 1, 50);
        wr(0, mk(0, 9), 1'b0);
        wr(0, mk(0, 10), 1'b0);
        wr(0, mk(0, 11), 1'b1);
        wait_done("t3_push_en_done", 2, 50);
        check("t3_words", 64'(got_q.size()), 64'(11));
        for (int i = 0; i < got_q.size(); i++) check("t3_data", 64'(got_q[i]), 64'(mk(0, i + 1)));
        check("t3_almost_a", 64'(almost_q[0]), 64'(7));
        check("t3_almost_b", 64'(almost_q[1]), 64'(10));
        push_only(0);
        repeat (10) tick();
        check("t3_empty_push", 64'(ch_q.size()), 64'(2));

        // 4) 16 words to each channel, served 0,1,2,3 with payload intact
        clear_mon();
        for (int c = 0; c < 4; c++) begin
            for (int i = 1; i <= 16; i++) wr(c, mk(c, i), 1'b0);
        end
        wait_done("t4_done", 4, 300);
        check("t4_xfers", 64'(ch_q.size()), 64'(4));
        for (int c = 0; c < ch_q.size(); c++) check("t4_order", 64'(ch_q[c]), 64'(c));
        check("t4_words", 64'(got_q.size()), 64'(64));
        for (int i = 0; i < got_q.size(); i++) check("t4_data", 64'(got_q[i]), 64'(mk(i / 16, i % 16 + 1)));

        // 5) overfill ch2 with no reads
        clear_mon();
        consume = 1'b0;
        for (int i = 1; i <= DEPTH + 3; i++) begin
            wr(2, mk(2, i), 1'b0);
            if (i == 1015) check("t5_almost_free9", 64'(almost_unwriteable), 64'(4'b0000));
            if (i == 1016) check("t5_almost_free8", 64'(almost_unwriteable), 64'(4'b0100));
            if (i == 1023) check("t5_writeable_free1", 64'(writeable), 64'(4'b1111));
            if (i == 1024) check("t5_full", 64'({overflow, writeable}), 64'({4'b0000, 4'b1011}));
        end
        check("t5_overflow", 64'(overflow), 64'(4'b0100));
        check("t5_writeable", 64'(writeable), 64'(4'b1011));
        check("t5_req_ch2", 64'({rd_xfer_req, rd_ch}), 64'({1'b1, 2'd2}));
        for (int i = 1; i <= 16; i++) wr(1, mk(1, i), 1'b0);
        check("t5_others_ok", 64'({overflow, writeable}), 64'({4'b0100, 4'b1011}));
        consume = 1'b1;
        rd_en   = rd_xfer_req && !rd_xfer_done;
        wait_done("t5_drain", 65, 4000);
        n1 = 0; n2 = 0; bad1 = 0; bad2 = 0; last2 = '0;
        foreach (got_q[k]) begin
            if (got_q[k][35:32] == 4'd2) begin
                n2++;
                last2 = got_q[k];
                if (got_q[k] !== mk(2, n2)) bad2++;
            end else if (got_q[k][35:32] == 4'd1) begin
                n1++;
                if (got_q[k] !== mk(1, n1)) bad1++;
            end
        end
        check("t5_ch2_words", 64'(n2), 64'(DEPTH));
        check("t5_ch2_bad", 64'(bad2), 64'(0));
        check("t5_ch2_last", 64'(last2), 64'(mk(2, DEPTH)));
        check("t5_ch1_words", 64'(n1), 64'(16));
        check("t5_ch1_bad", 64'(bad1), 64'(0));
        repeat (2) tick();
        check("t5_drained", 64'({overflow, writeable}), 64'({4'b0100, 4'b1111}));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req_prev = 1'b0;
        check("t5_rst_overflow", 64'(overflow), 64'(0));

`ifdef MCFIFO_PKT_BUF_AUTOPUSH_EN
        // 6a) idle auto-push of a 5-word partial packet on ch1
        clear_mon();
        for (int i = 1; i <= 5; i++) wr(1, mk(1, i), 1'b0);
        lat = 0;
        while (!rd_xfer_req && lat < 300) begin
            tick();
            lat++;
        end
        check("t6_ap_latency", 64'((lat >= 99) && (lat <= 105)), 64'(1));
        check("t6_ap_ch", 64'(rd_ch), 64'(1));
        wait_done("t6_ap_done", 1, 50);
        check("t6_ap_words", 64'(got_q.size()), 64'(5));
        for (int i = 0; i < got_q.size(); i++) check("t6_ap_data", 64'(got_q[i]), 64'(mk(1, i + 1)));
`endif

        // 6b) asynchronous reset in the middle of a transfer
        clear_mon();
        for (int i = 1; i <= 16; i++) begin
            wr(3, mk(3, i), 1'b0);
            if (got_q.size() >= 5) break;
        end
        lat = 0;
        while (got_q.size() < 5 && lat < 100) begin
            tick();
            lat++;
        end
        check("t6_mid_xfer", 64'(rd_xfer_req), 64'(1));
        #2 reset = 1'b1;
        #1;
        check("t6_async_req_valid", 64'({rd_xfer_req, rd_valid}), 64'(0));
        check("t6_async_writeable", 64'(writeable), 64'(4'hf));
        @(negedge clk);
        reset    = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        req_prev = 1'b0;
        base_got  = got_q.size();
        base_done = done_cnt;
        base_ch   = ch_q.size();
        repeat (30) tick();
        check("t6_no_data", 64'(got_q.size()), 64'(base_got));
        check("t6_no_done", 64'(done_cnt), 64'(base_done));
        check("t6_no_xfer", 64'({rd_xfer_req, 32'(ch_q.size())}), 64'({1'b0, 32'(base_ch)}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
